// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle MIPS-subset datapath.
// One state per datapath step; outputs are decoded combinationally from the state.
//
// Ports:
//   clk, reset (sync, active-low)     clock and reset
//   opcode[5:0], funct[5:0], zero     IR fields and ALU zero flag
//   pc_write, mux_pc_control[1:0]     PC load enable and PC source select
//   mux_iord, mem_wr                  memory address select, memory write
//   ir_wr, mdr_wr, a_b_wr, aluout_wr  datapath register loads
//   reg_wr, mux_regdst, mux_memtoreg  register-file write and its selects
//   mux_a_control, mux_b_control[1:0] ALU operand selects
//   alu_control[2:0], epc_wr          ALU operation, EPC load
//   state_out[3:0]                    current state (debug)
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] mux_pc_control,
  output logic       mux_iord,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       mdr_wr,
  output logic       a_b_wr,
  output logic       aluout_wr,
  output logic       reg_wr,
  output logic       mux_regdst,
  output logic       mux_memtoreg,
  output logic       mux_a_control,
  output logic [1:0] mux_b_control,
  output logic [2:0] alu_control,
  output logic       epc_wr,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_IR_LOAD   = 4'd2,
    S_DECODE    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WAIT  = 4'd6,
    S_LW_WB     = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_R_EXEC    = 4'd9,
    S_R_WB      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12,
    S_BRANCH    = 4'd13,
    S_JUMP      = 4'd14,
    S_EXC       = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  state_t r_state;
  state_t w_next;
  logic   w_funct_ok;

  assign w_funct_ok = (funct == FN_ADD) ||
                      (funct == FN_SUB) ||
                      (funct == FN_AND);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  assign state_out = r_state;

  always_comb begin
    w_next         = S_FETCH;
    pc_write       = 1'b0;
    mux_pc_control = 2'b00;
    mux_iord       = 1'b0;
    mem_wr         = 1'b0;
    ir_wr          = 1'b0;
    mdr_wr         = 1'b0;
    a_b_wr         = 1'b0;
    aluout_wr      = 1'b0;
    reg_wr         = 1'b0;
    mux_regdst     = 1'b0;
    mux_memtoreg   = 1'b0;
    mux_a_control  = 1'b0;
    mux_b_control  = 2'b00;
    alu_control    = 3'b000;
    epc_wr         = 1'b0;

    unique case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        mux_b_control = 2'b01;
        alu_control   = ALU_ADD;
        pc_write      = 1'b1;
        w_next        = S_IR_LOAD;
      end
      S_IR_LOAD: begin
        ir_wr  = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target: PC+4 + (imm<<2)
        a_b_wr        = 1'b1;
        mux_b_control = 2'b11;
        alu_control   = ALU_ADD;
        aluout_wr     = 1'b1;
        case (opcode)
          OP_LW, OP_SW:    w_next = S_MEM_ADDR;
          OP_R:            w_next = w_funct_ok ? S_R_EXEC : S_EXC;
          OP_ADDI:         w_next = S_I_EXEC;
          OP_BEQ, OP_BNE:  w_next = S_BRANCH;
          OP_J:            w_next = S_JUMP;
          default:         w_next = S_EXC;
        endcase
      end
      S_MEM_ADDR: begin
        mux_a_control = 1'b1;
        mux_b_control = 2'b10;
        alu_control   = ALU_ADD;
        aluout_wr     = 1'b1;
        w_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mux_iord = 1'b1;
        w_next   = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        mux_iord = 1'b1;
        mdr_wr   = 1'b1;
        w_next   = S_LW_WB;
      end
      S_LW_WB: begin
        reg_wr       = 1'b1;
        mux_memtoreg = 1'b1;
      end
      S_MEM_WRITE: begin
        mux_iord = 1'b1;
        mem_wr   = 1'b1;
      end
      S_R_EXEC: begin
        mux_a_control = 1'b1;
        aluout_wr     = 1'b1;
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          default: alu_control = 3'b000;
        endcase
        w_next = S_R_WB;
      end
      S_R_WB: begin
        reg_wr     = 1'b1;
        mux_regdst = 1'b1;
      end
      S_I_EXEC: begin
        mux_a_control = 1'b1;
        mux_b_control = 2'b10;
        alu_control   = ALU_ADD;
        aluout_wr     = 1'b1;
        w_next        = S_I_WB;
      end
      S_I_WB: reg_wr = 1'b1;
      S_BRANCH: begin
        // Compare A-B; only output that looks at an input
        mux_a_control  = 1'b1;
        alu_control    = ALU_SUB;
        mux_pc_control = 2'b01;
        pc_write       = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        mux_pc_control = 2'b10;
        pc_write       = 1'b1;
      end
      S_EXC: begin
        // PC already holds PC+4 from FETCH
        epc_wr         = 1'b1;
        mux_pc_control = 2'b11;
        pc_write       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed-vector bench for the multicycle control FSM.
// Walks each instruction class state by state against hand-written expectations.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_write;
  logic [1:0] mux_pc_control;
  logic       mux_iord;
  logic       mem_wr;
  logic       ir_wr;
  logic       mdr_wr;
  logic       a_b_wr;
  logic       aluout_wr;
  logic       reg_wr;
  logic       mux_regdst;
  logic       mux_memtoreg;
  logic       mux_a_control;
  logic [1:0] mux_b_control;
  logic [2:0] alu_control;
  logic       epc_wr;
  logic [3:0] state_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .funct          (funct),
    .zero           (zero),
    .pc_write       (pc_write),
    .mux_pc_control (mux_pc_control),
    .mux_iord       (mux_iord),
    .mem_wr         (mem_wr),
    .ir_wr          (ir_wr),
    .mdr_wr         (mdr_wr),
    .a_b_wr         (a_b_wr),
    .aluout_wr      (aluout_wr),
    .reg_wr         (reg_wr),
    .mux_regdst     (mux_regdst),
    .mux_memtoreg   (mux_memtoreg),
    .mux_a_control  (mux_a_control),
    .mux_b_control  (mux_b_control),
    .alu_control    (alu_control),
    .epc_wr         (epc_wr),
    .state_out      (state_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {pc_write, mux_pc[1:0], iord, mem_wr, ir_wr, mdr_wr, a_b_wr,
  //  aluout_wr, reg_wr, regdst, memtoreg, mux_a, mux_b[1:0], alu[2:0], epc}
  function automatic logic [18:0] act_ctl();
    return {pc_write, mux_pc_control, mux_iord, mem_wr, ir_wr, mdr_wr,
            a_b_wr, aluout_wr, reg_wr, mux_regdst, mux_memtoreg,
            mux_a_control, mux_b_control, alu_control, epc_wr};
  endfunction

  function automatic logic [18:0] exp_ctl(input logic [3:0] st,
                                          input logic [5:0] op,
                                          input logic [5:0] fn,
                                          input logic z);
    logic pcw, iord, mw, irw, mdw, abw, aow, rw, rd, m2r, ma, epc;
    logic [1:0] mpc, mb;
    logic [2:0] alu;
    {pcw, iord, mw, irw, mdw, abw, aow, rw, rd, m2r, ma, epc} = '0;
    mpc = 2'b00; mb = 2'b00; alu = 3'b000;
    case (st)
      4'd1:  begin pcw = 1; mb = 2'b01; alu = 3'b001; end
      4'd2:  irw = 1;
      4'd3:  begin abw = 1; mb = 2'b11; alu = 3'b001; aow = 1; end
      4'd4:  begin ma = 1; mb = 2'b10; alu = 3'b001; aow = 1; end
      4'd5:  iord = 1;
      4'd6:  begin iord = 1; mdw = 1; end
      4'd7:  begin rw = 1; m2r = 1; end
      4'd8:  begin iord = 1; mw = 1; end
      4'd9:  begin
        ma = 1; aow = 1;
        alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      end
      4'd10: begin rw = 1; rd = 1; end
      4'd11: begin ma = 1; mb = 2'b10; alu = 3'b001; aow = 1; end
      4'd12: rw = 1;
      4'd13: begin
        ma = 1; alu = 3'b010; mpc = 2'b01;
        pcw = (op == 6'h04) ? z : ~z;
      end
      4'd14: begin mpc = 2'b10; pcw = 1; end
      4'd15: begin epc = 1; mpc = 2'b11; pcw = 1; end
      default: ;
    endcase
    return {pcw, mpc, iord, mw, irw, mdw, abw, aow, rw, rd, m2r,
            ma, mb, alu, epc};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts at a FETCH negedge; seq holds n expected states, MSB nibble first.
  task automatic run_instr(input string nm, input logic [5:0] op,
                           input logic [5:0] fn, input logic z,
                           input logic [31:0] seq, input int n);
    logic [3:0] s;
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < n; i++) begin
      s = seq[31-4*i -: 4];
      chk($sformatf("%s st%0d", nm, i), {28'd0, state_out}, {28'd0, s});
      chk($sformatf("%s ctl%0d", nm, i), {13'd0, act_ctl()},
          {13'd0, exp_ctl(s, op, fn, z)});
      chk($sformatf("%s excl%0d", nm, i), {31'd0, mem_wr & reg_wr}, 32'd0);
      if (i < n - 1) step();
    end
  endtask

  initial begin
    reset  = 1'b0;
    opcode = 6'h00;
    funct  = 6'h20;
    zero   = 1'b0;

    // Reset hold
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst st", {28'd0, state_out}, 32'd0);
      chk("rst ctl", {13'd0, act_ctl()}, 32'd0);
    end
    reset = 1'b1;
    step();
    chk("rel st", {28'd0, state_out}, 32'd1);
    chk("rel pcw", {31'd0, pc_write}, 32'd1);
    chk("rel mb", {30'd0, mux_b_control}, 32'd1);
    chk("rel alu", {29'd0, alu_control}, 32'd1);

    run_instr("lw",    6'h23, 6'h00, 1'b0, 32'h12345671, 8);
    run_instr("sw",    6'h2B, 6'h00, 1'b0, 32'h12348100, 6);
    run_instr("add",   6'h00, 6'h20, 1'b0, 32'h1239A100, 6);
    run_instr("sub",   6'h00, 6'h22, 1'b1, 32'h1239A100, 6);
    run_instr("and",   6'h00, 6'h24, 1'b0, 32'h1239A100, 6);
    run_instr("addi",  6'h08, 6'h00, 1'b0, 32'h123BC100, 6);
    run_instr("beq1",  6'h04, 6'h00, 1'b1, 32'h123D1000, 5);
    run_instr("beq0",  6'h04, 6'h00, 1'b0, 32'h123D1000, 5);
    run_instr("bne0",  6'h05, 6'h00, 1'b0, 32'h123D1000, 5);
    run_instr("bne1",  6'h05, 6'h00, 1'b1, 32'h123D1000, 5);
    run_instr("j",     6'h02, 6'h00, 1'b0, 32'h123E1000, 5);
    run_instr("ill3f", 6'h3F, 6'h00, 1'b0, 32'h123F1000, 5);
    run_instr("illfn", 6'h00, 6'h21, 1'b0, 32'h123F1000, 5);

    // Reset from DECODE
    opcode = 6'h23;
    step();
    step();
    chk("mid dec st", {28'd0, state_out}, 32'd3);
    reset = 1'b0;
    step();
    chk("mid dec rst", {28'd0, state_out}, 32'd0);
    reset = 1'b1;
    step();
    chk("mid dec rel", {28'd0, state_out}, 32'd1);

    // Reset while in MEM_WRITE
    opcode = 6'h2B;
    for (int i = 0; i < 4; i++) step();
    chk("mw st", {28'd0, state_out}, 32'd8);
    chk("mw memwr", {31'd0, mem_wr}, 32'd1);
    reset = 1'b0;
    step();
    chk("mw rst st", {28'd0, state_out}, 32'd0);
    chk("mw rst memwr", {31'd0, mem_wr}, 32'd0);
    step();
    chk("mw hold memwr", {31'd0, mem_wr}, 32'd0);
    reset = 1'b1;
    step();
    chk("mw rel st", {28'd0, state_out}, 32'd1);
    chk("mw rel memwr", {31'd0, mem_wr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style finite state machine that sequences the multicycle MIPS-subset datapath. It drives:
- the ALU operand multiplexers, including the 2-bit ALU-B select;
- the PC, memory-address and writeback multiplexers;
- every register and memory write enable.

Inputs are the opcode/funct fields of the instruction register and the ALU zero flag. It sits between the instruction register and all datapath control pins.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; sampled only on the rising edge of clk.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- pc_write  out  1  PC load enable.
- mux_pc_control  out  2  PC source select:
  - 00 ALU result;
  - 01 ALUOut register;
  - 10 jump target;
  - 11 exception vector.
- mux_iord  out  1  memory address source: 0 PC, 1 ALUOut.
- mem_wr  out  1  memory write enable.
- ir_wr  out  1  instruction register load.
- mdr_wr  out  1  memory data register load.
- a_b_wr  out  1  A/B register load.
- aluout_wr  out  1  ALUOut register load.
- reg_wr  out  1  register-file write.
- mux_regdst  out  1  destination register: 0 rt, 1 rd.
- mux_memtoreg  out  1  writeback source: 0 ALUOut, 1 MDR.
- mux_a_control  out  1  ALU A source: 0 PC, 1 regA.
- mux_b_control  out  2  ALU B source:
  - 00 regB;
  - 01 constant 4;
  - 10 sign-extended immediate;
  - 11 immediate shifted left 2.
- alu_control  out  3  ALU operation: 001 add, 010 sub, 011 and.
- epc_wr  out  1  EPC load.
- state_out  out  4  current state encoding (debug/verification).

## Operation
- Supported instructions:
  - R-type (opcode 0x00) with funct 0x20 add, 0x22 sub, 0x24 and;
  - addi 0x08;
  - beq 0x04;
  - bne 0x05;
  - lw 0x23;
  - sw 0x2B;
  - j 0x02.
- Any other opcode, or an R-type with any other funct, is illegal.
- State encodings: RESET 0, FETCH 1, IR_LOAD 2, DECODE 3, MEM_ADDR 4, MEM_READ 5, MEM_WAIT 6, LW_WB 7, MEM_WRITE 8, R_EXEC 9, R_WB 10, I_EXEC 11, I_WB 12, BRANCH 13, JUMP 14, EXC 15.
- Every output not listed for a state is 0 in that state.
- Per-state outputs and transitions:
  - RESET: all outputs 0. → FETCH.
  - FETCH: mux_iord=0, mux_a=0, mux_b=01, alu=001, mux_pc=00, pc_write=1. → IR_LOAD.
  - IR_LOAD: ir_wr=1. → DECODE.
  - DECODE: a_b_wr=1, mux_a=0, mux_b=11, alu=001, aluout_wr=1 (computes branch target). Next state by opcode:
    - lw/sw → MEM_ADDR;
    - R-type with legal funct → R_EXEC;
    - addi → I_EXEC;
    - beq/bne → BRANCH;
    - j → JUMP;
    - illegal → EXC.
  - MEM_ADDR: mux_a=1, mux_b=10, alu=001, aluout_wr=1. → MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: mux_iord=1. → MEM_WAIT.
  - MEM_WAIT: mux_iord=1, mdr_wr=1. → LW_WB.
  - LW_WB: reg_wr=1, mux_regdst=0, mux_memtoreg=1. → FETCH.
  - MEM_WRITE: mux_iord=1, mem_wr=1. → FETCH.
  - R_EXEC: mux_a=1, mux_b=00, aluout_wr=1, alu by funct (0x20→001, 0x22→010, 0x24→011). → R_WB.
  - R_WB: reg_wr=1, mux_regdst=1, mux_memtoreg=0. → FETCH.
  - I_EXEC: mux_a=1, mux_b=10, alu=001, aluout_wr=1. → I_WB.
  - I_WB: reg_wr=1, mux_regdst=0, mux_memtoreg=0. → FETCH.
  - BRANCH: mux_a=1, mux_b=00, alu=010, mux_pc=01. pc_write=zero for beq, ~zero for bne (the only Mealy output). → FETCH.
  - JUMP: mux_pc=10, pc_write=1. → FETCH.
  - EXC: epc_wr=1 (captures the already-incremented PC), mux_pc=11, pc_write=1. → FETCH.
- opcode and funct are used only in DECODE, R_EXEC, MEM_ADDR and BRANCH. They are stable from IR_LOAD+1 until the next IR_LOAD.

## Timing
- Reset:
  - reset=0 at a rising edge → state=RESET on the next cycle, regardless of the current state, including mid-instruction and during MEM_WRITE.
  - While in RESET, all outputs are 0 and state_out=0.
  - The first edge with reset=1 moves the FSM to FETCH.
- Outputs are decoded combinationally from the state register; only pc_write in BRANCH also depends on zero. No output is registered.
- Memory read latency is 1 cycle. The address is presented in FETCH/MEM_READ; data is captured in IR_LOAD/MEM_WAIT.
- Cycles per instruction, FETCH through the last state inclusive:
  - j, beq, bne: 4;
  - illegal: 4;
  - sw: 5;
  - R-type: 5;
  - addi: 5;
  - lw: 7.
- The cycle after each last state is FETCH.
- Exactly one pc_write pulse per FETCH. At most one additional pulse per instruction (BRANCH taken, JUMP, EXC).
- mem_wr and reg_wr never assert in the same cycle. ir_wr asserts only in IR_LOAD.

## Test plan
- Reset hold: reset=0 for 3 cycles from an arbitrary state → state_out=0 and all outputs 0; release → FETCH with pc_write=1, mux_b_control=01, alu_control=001.
- Load: opcode=0x23 → state sequence 1,2,3,4,5,6,7,1; mux_b_control=10 in MEM_ADDR; reg_wr=1 with mux_memtoreg=1 only in LW_WB.
- R-type sub: opcode=0x00, funct=0x22 → R_EXEC shows alu_control=010 and mux_b_control=00; R_WB shows reg_wr=1 and mux_regdst=1; 5 cycles total.
- Branches:
  - beq with zero=1 → pc_write=1, mux_pc_control=01 in BRANCH;
  - beq with zero=0 → pc_write=0;
  - bne with zero=0 → pc_write=1.
- Illegal: opcode=0x3F, then opcode=0x00 with funct=0x21 → each goes DECODE→EXC with epc_wr=1, mux_pc_control=11, pc_write=1, then FETCH.
- Mid-instruction reset: reset=0 asserted while in MEM_WRITE → next cycle state=RESET with mem_wr=0; no further writes.
